// File: rtl/flags_ctrl.sv
// flags_ctrl
//   Control logic for the processor FLAGS register (bit0 Z, bit1 N, bit2 C, bit3 V).
//   It arbitrates flag writes, keeps a 4-deep shadow stack for interrupt
//   save/restore, and evaluates branch conditions.
//
// Ports
//   clk        in   rising-edge clock
//   rst_b      in   asynchronous active-low reset
//   flags_q    in   current FLAGS register value
//   alu_we     in   ALU flag-update request
//   alu_flags  in   ALU-produced flags
//   alu_mask   in   per-bit update mask for alu_flags (1 = update)
//   ld_we      in   explicit whole-flags load request
//   ld_flags   in   value for the explicit load
//   push       in   save flags_q on the shadow stack
//   pop        in   restore flags from the shadow stack
//   err_clr    in   clear the sticky stack error
//   cond       in   branch condition code
//   flags_en   out  FLAGS register write enable (combinational)
//   flags_d    out  FLAGS register write data (combinational)
//   cond_ok    out  condition evaluated on flags_q
//   depth      out  shadow stack occupancy 0..4 (registered)
//   stk_full   out  depth == 4
//   stk_empty  out  depth == 0
//   stk_err    out  sticky overflow / underflow / conflict error
module flags_ctrl (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [3:0] flags_q,
  input  logic       alu_we,
  input  logic [3:0] alu_flags,
  input  logic [3:0] alu_mask,
  input  logic       ld_we,
  input  logic [3:0] ld_flags,
  input  logic       push,
  input  logic       pop,
  input  logic       err_clr,
  input  logic [2:0] cond,
  output logic       flags_en,
  output logic [3:0] flags_d,
  output logic       cond_ok,
  output logic [2:0] depth,
  output logic       stk_full,
  output logic       stk_empty,
  output logic       stk_err
);

  logic [3:0] r_stk [4];
  logic [2:0] r_depth;
  logic       r_err;

  logic       w_full;
  logic       w_empty;
  logic       w_push_ok;
  logic       w_pop_ok;
  logic       w_err_evt;
  logic [1:0] w_top_idx;
  logic [3:0] w_alu_merge;

  assign w_full    = (r_depth == 3'd4);
  assign w_empty   = (r_depth == 3'd0);
  assign w_push_ok = push & ~pop & ~w_full;
  assign w_pop_ok  = pop & ~push & ~w_empty;
  // Overflow, underflow and push+pop conflict all count as stack errors.
  assign w_err_evt = (push & pop) | (push & ~pop & w_full) | (pop & ~push & w_empty);
  // depth 1..4 maps to top index 0..3; the 2-bit wrap handles depth 4 -> 3.
  assign w_top_idx = r_depth[1:0] - 2'd1;
  assign w_alu_merge = (flags_q & ~alu_mask) | (alu_flags & alu_mask);

  // Write arbitration: valid pop > ld_we > alu_we. Held off while in reset.
  always_comb begin
    flags_en = 1'b0;
    flags_d  = flags_q;
    if (w_pop_ok) begin
      flags_en = 1'b1;
      flags_d  = r_stk[w_top_idx];
    end else if (ld_we) begin
      flags_en = 1'b1;
      flags_d  = ld_flags;
    end else if (alu_we) begin
      flags_en = (alu_mask != 4'd0);
      flags_d  = w_alu_merge;
    end
    if (!rst_b) begin
      flags_en = 1'b0;
    end
  end

  always_comb begin
    cond_ok = 1'b1;
    case (cond)
      3'd0: cond_ok = 1'b1;
      3'd1: cond_ok = flags_q[0];
      3'd2: cond_ok = ~flags_q[0];
      3'd3: cond_ok = flags_q[2];
      3'd4: cond_ok = ~flags_q[2];
      3'd5: cond_ok = flags_q[1];
      3'd6: cond_ok = flags_q[1] ^ flags_q[3];
      3'd7: cond_ok = ~(flags_q[1] ^ flags_q[3]);
      default: cond_ok = 1'b1;
    endcase
  end

  // Stack state: push saves flags_q as sampled this cycle, before any
  // FLAGS update that lands on the same edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_depth <= 3'd0;
      r_err   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_stk[i] <= 4'd0;
      end
    end else begin
      if (w_push_ok) begin
        r_stk[r_depth[1:0]] <= flags_q;
        r_depth             <= r_depth + 3'd1;
      end else if (w_pop_ok) begin
        r_depth <= r_depth - 3'd1;
      end
      // A new error in the same cycle as err_clr keeps the flag set.
      if (w_err_evt) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign depth     = r_depth;
  assign stk_full  = w_full;
  assign stk_empty = w_empty;
  assign stk_err   = r_err;

endmodule

// File: tb/tb_flags_ctrl.sv
module tb_flags_ctrl;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [3:0] flags_q;
  logic       alu_we;
  logic [3:0] alu_flags;
  logic [3:0] alu_mask;
  logic       ld_we;
  logic [3:0] ld_flags;
  logic       push;
  logic       pop;
  logic       err_clr;
  logic [2:0] cond;
  logic       flags_en;
  logic [3:0] flags_d;
  logic       cond_ok;
  logic [2:0] depth;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_err;

  int n_chk = 0;
  int n_err = 0;

  flags_ctrl dut (
    .clk(clk), .rst_b(rst_b), .flags_q(flags_q),
    .alu_we(alu_we), .alu_flags(alu_flags), .alu_mask(alu_mask),
    .ld_we(ld_we), .ld_flags(ld_flags), .push(push), .pop(pop),
    .err_clr(err_clr), .cond(cond), .flags_en(flags_en), .flags_d(flags_d),
    .cond_ok(cond_ok), .depth(depth), .stk_full(stk_full),
    .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic idle();
    alu_we = 0; alu_flags = 0; alu_mask = 0; ld_we = 0; ld_flags = 0;
    push = 0; pop = 0; err_clr = 0;
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reading of the condition table.
  function automatic logic exp_cond(input logic [2:0] c, input logic [3:0] f);
    logic z, n, cy, v;
    z = f[0]; n = f[1]; cy = f[2]; v = f[3];
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return cy;
      3'd4: return !cy;
      3'd5: return n;
      3'd6: return n != v;
      default: return n == v;
    endcase
  endfunction

  logic [3:0] fill_vals [4];
  logic [3:0] cond_flags [5];

  initial begin
    fill_vals  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    cond_flags = '{4'b0000, 4'b0001, 4'b0100, 4'b1000, 4'b1100};
    idle();
    cond = 0;
    flags_q = 4'b0000;
    rst_b = 0;
    // Requests present during reset must not enable a write.
    ld_we = 1; ld_flags = 4'b1111; alu_we = 1; alu_mask = 4'b1111;
    #12;
    chk("rst_en", {7'd0, flags_en}, 8'd0);
    chk("rst_depth", {5'd0, depth}, 8'd0);
    chk("rst_empty", {7'd0, stk_empty}, 8'd1);
    chk("rst_full", {7'd0, stk_full}, 8'd0);
    chk("rst_err", {7'd0, stk_err}, 8'd0);
    idle();
    @(negedge clk);
    rst_b = 1;
    tick();

    // ALU merge
    flags_q = 4'b0101; alu_we = 1; alu_flags = 4'b1010; alu_mask = 4'b0011;
    #1;
    chk("merge_en", {7'd0, flags_en}, 8'd1);
    chk("merge_d", {4'd0, flags_d}, 8'b0110);
    alu_mask = 4'b0000;
    #1;
    chk("merge_m0_en", {7'd0, flags_en}, 8'd0);
    chk("merge_m0_d", {4'd0, flags_d}, 8'b0101);
    // ld_we beats alu_we
    alu_mask = 4'b1111; ld_we = 1; ld_flags = 4'b0011;
    #1;
    chk("ld_over_alu_d", {4'd0, flags_d}, 8'b0011);
    chk("ld_over_alu_en", {7'd0, flags_en}, 8'd1);
    idle();
    #1;
    chk("none_en", {7'd0, flags_en}, 8'd0);
    chk("none_d", {4'd0, flags_d}, 8'b0101);

    // Priority: pop beats ld and alu
    flags_q = 4'b1001; push = 1;
    tick();
    idle();
    flags_q = 4'b0000;
    chk("pri_depth1", {5'd0, depth}, 8'd1);
    pop = 1; ld_we = 1; ld_flags = 4'b0110; alu_we = 1; alu_flags = 4'b1111; alu_mask = 4'b1111;
    #1;
    chk("pri_d", {4'd0, flags_d}, 8'b1001);
    chk("pri_en", {7'd0, flags_en}, 8'd1);
    tick();
    idle();
    chk("pri_depth0", {5'd0, depth}, 8'd0);
    chk("pri_err", {7'd0, stk_err}, 8'd0);

    // Fill and overflow; push saves pre-update flags_q even with ld_we active
    for (int i = 0; i < 4; i++) begin
      flags_q = fill_vals[i]; push = 1; ld_we = 1; ld_flags = 4'b1111;
      tick();
    end
    idle();
    chk("fill_depth", {5'd0, depth}, 8'd4);
    chk("fill_full", {7'd0, stk_full}, 8'd1);
    chk("fill_empty", {7'd0, stk_empty}, 8'd0);
    flags_q = 4'b1111; push = 1;
    tick();
    idle();
    chk("ovf_depth", {5'd0, depth}, 8'd4);
    chk("ovf_err", {7'd0, stk_err}, 8'd1);
    for (int i = 3; i >= 0; i--) begin
      pop = 1;
      #1;
      chk($sformatf("pop%0d_d", 3 - i), {4'd0, flags_d}, {4'd0, fill_vals[i]});
      chk($sformatf("pop%0d_en", 3 - i), {7'd0, flags_en}, 8'd1);
      tick();
    end
    idle();
    chk("drain_depth", {5'd0, depth}, 8'd0);
    chk("drain_empty", {7'd0, stk_empty}, 8'd1);

    // Underflow
    err_clr = 1;
    tick();
    idle();
    chk("clr1_err", {7'd0, stk_err}, 8'd0);
    flags_q = 4'b0000; pop = 1; ld_we = 1; ld_flags = 4'b1111;
    #1;
    chk("unf_d", {4'd0, flags_d}, 8'b1111);
    chk("unf_en", {7'd0, flags_en}, 8'd1);
    tick();
    idle();
    chk("unf_err", {7'd0, stk_err}, 8'd1);
    chk("unf_depth", {5'd0, depth}, 8'd0);
    err_clr = 1;
    tick();
    idle();
    chk("clr2_err", {7'd0, stk_err}, 8'd0);

    // Conflict at depth 2
    flags_q = 4'b0011; push = 1; tick();
    flags_q = 4'b0110; tick();
    idle();
    chk("cf_depth_pre", {5'd0, depth}, 8'd2);
    push = 1; pop = 1; flags_q = 4'b0101;
    #1;
    chk("cf_en", {7'd0, flags_en}, 8'd0);
    chk("cf_d", {4'd0, flags_d}, 8'b0101);
    tick();
    idle();
    chk("cf_depth", {5'd0, depth}, 8'd2);
    chk("cf_err", {7'd0, stk_err}, 8'd1);
    // Error in the same cycle as err_clr wins
    err_clr = 1; push = 1; pop = 1;
    tick();
    idle();
    chk("clr_vs_err", {7'd0, stk_err}, 8'd1);
    // Stack content survived the conflict
    pop = 1;
    #1;
    chk("cf_top", {4'd0, flags_d}, 8'b0110);
    idle();

    // Condition sweep
    for (int f = 0; f < 5; f++) begin
      for (int c = 0; c < 8; c++) begin
        flags_q = cond_flags[f]; cond = 3'(c);
        #1;
        chk($sformatf("cond f=%b c=%0d", cond_flags[f], c), {7'd0, cond_ok},
            {7'd0, exp_cond(3'(c), cond_flags[f])});
      end
    end

    // Reset mid-operation at depth 3 with error set
    flags_q = 4'b1110; push = 1;
    tick();
    idle();
    chk("mid_depth3", {5'd0, depth}, 8'd3);
    #2;
    rst_b = 0;
    #1;
    chk("mid_rst_depth", {5'd0, depth}, 8'd0);
    chk("mid_rst_err", {7'd0, stk_err}, 8'd0);
    chk("mid_rst_empty", {7'd0, stk_empty}, 8'd1);
    @(negedge clk);
    rst_b = 1;
    tick();
    pop = 1;
    #1;
    chk("post_rst_en", {7'd0, flags_en}, 8'd0);
    tick();
    idle();
    chk("post_rst_err", {7'd0, stk_err}, 8'd1);
    chk("post_rst_depth", {5'd0, depth}, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/flags_ctrl.md
FLAGS_CTRL -- requirements
Module: flags_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_b.
REQ-002 Ports:
  - clk  in  1  clock, rising edge
  - rst_b  in  1  async active-low reset
  - flags_q  in  4  current FLAGS register output; bit0 Z, bit1 N, bit2 C, bit3 V
  - alu_we  in  1  ALU flag-update request
  - alu_flags  in  4  ALU-produced flags
  - alu_mask  in  4  per-bit update mask for alu_flags (1 = update)
  - ld_we  in  1  explicit whole-flags load request (load-flags instruction)
  - ld_flags  in  4  value for explicit load
  - push  in  1  save flags_q onto shadow stack (interrupt entry)
  - pop  in  1  restore flags from shadow stack (interrupt return)
  - err_clr  in  1  clear sticky stack error
  - cond  in  3  branch condition code
  - flags_en  out  1  enable to the FLAGS register
  - flags_d  out  4  data to the FLAGS register
  - cond_ok  out  1  condition evaluation of flags_q
  - depth  out  3  shadow stack occupancy, 0..4
  - stk_full  out  1  depth == 4
  - stk_empty  out  1  depth == 0
  - stk_err  out  1  sticky overflow/underflow/conflict error

Function
REQ-003 Shadow stack SHALL be a 4-entry LIFO of 4-bit entries with a 3-bit depth counter; entries and depth are registered.
REQ-004 Valid push (push=1, pop=0, depth<4) SHALL write flags_q into entry[depth] and increment depth at the clock edge; the value saved is flags_q before any same-cycle FLAGS update.
REQ-005 Valid pop (pop=1, push=0, depth>0) SHALL drive flags_d = entry[depth-1], flags_en = 1 combinationally, and decrement depth at the clock edge.
REQ-006 Write priority SHALL be: valid pop > ld_we > alu_we; the losing requests are dropped with no error.
REQ-007 ld_we winner SHALL drive flags_d = ld_flags and flags_en = 1.
REQ-008 alu_we winner SHALL drive flags_d = (flags_q AND NOT alu_mask) OR (alu_flags AND alu_mask); flags_en = 1 only if alu_mask != 0.
REQ-009 With no winning request: flags_en = 0 and flags_d = flags_q.
REQ-010 push at depth 4 (overflow) SHALL be ignored and set stk_err.
REQ-011 pop at depth 0 (underflow) SHALL be ignored and set stk_err; ld_we and alu_we then arbitrate normally.
REQ-012 push and pop in the same cycle SHALL be a conflict:
  - stack and depth unchanged, no restore, stk_err set;
  - ld_we and alu_we arbitrate normally.
REQ-013 stk_err SHALL be sticky until err_clr=1, which clears it at the next edge; if a new error occurs in the same cycle as err_clr, the error wins (stk_err = 1).
REQ-014 cond_ok SHALL be combinational from flags_q:
  - 0 always 1
  - 1 Z
  - 2 NOT Z
  - 3 C
  - 4 NOT C
  - 5 N
  - 6 N XOR V
  - 7 NOT (N XOR V)
REQ-015 stk_full, stk_empty and depth SHALL reflect registered depth only, with no combinational path from push or pop.
REQ-016 flags_en and flags_d SHALL be combinational, with zero-cycle latency, so FLAGS captures the update at the same edge as the request.

Reset
REQ-017 While rst_b = 0:
  - depth = 0, all stack entries = 0, stk_err = 0;
  - stk_empty = 1, stk_full = 0;
  - flags_en = 0 regardless of inputs.
REQ-018 Reset asserted mid-sequence SHALL discard all saved entries; after release the first pop is an underflow.

Verification
REQ-019 Merge: flags_q=0101, alu_we=1, alu_flags=1010, alu_mask=0011 -> flags_en=1, flags_d=0110; with alu_mask=0000 -> flags_en=0.
REQ-020 Priority: depth=1 with entry0=1001; pop=1, ld_we=1 (ld_flags=0110), alu_we=1 in the same cycle -> flags_d=1001, flags_en=1, depth=0, stk_err=0.
REQ-021 Fill and overflow:
  - 4 pushes of flags_q = 0001, 0010, 0100, 1000 -> depth=4, stk_full=1;
  - 5th push -> depth stays 4, stk_err=1;
  - 4 pops -> flags_d = 1000, 0100, 0010, 0001 in order.
REQ-022 Underflow and conflict:
  - pop at depth 0 with ld_we=1, ld_flags=1111 -> flags_d=1111, stk_err=1;
  - err_clr -> stk_err=0;
  - push+pop together at depth 2 -> depth stays 2, stk_err=1.
REQ-023 Conditions: sweep cond 0..7 for flags_q in {0000, 0001, 0100, 1000, 1100} -> cond_ok matches the REQ-014 table in every case.
REQ-024 Reset mid-operation: depth=3, then rst_b pulsed low asynchronously between edges -> depth=0 and stk_err=0 immediately; after release, the next pop sets stk_err=1.
